// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch key-control and counter stages:
// mode encodings, key indices, default tick constants and a width helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_PAUSE = 2'd2
    } mode_e;

    localparam int KEY_START = 0;
    localparam int KEY_STOP  = 1;
    localparam int KEY_ADD   = 2;

    // Default tick constants (10 Hz clock)
    localparam int DEB_SAMPLES_DEF  = 2;
    localparam int HOLD_TICKS_DEF   = 10;
    localparam int REPEAT_TICKS_DEF = 3;

    // Bits needed to hold values 0..max_val (at least one bit)
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/stopwatch_key_ctrl_if.sv
// Key inputs and control outputs between the key panel and the counter stage.
interface stopwatch_key_ctrl_if;
    logic       start_n;
    logic       stop_n;
    logic       add_n;
    logic       run;
    logic       inc_pulse;
    logic       clr_pulse;
    logic [1:0] mode;
    logic [2:0] keys_db;

    modport master (
        output start_n, stop_n, add_n,
        input  run, inc_pulse, clr_pulse, mode, keys_db
    );

    modport slave (
        input  start_n, stop_n, add_n,
        output run, inc_pulse, clr_pulse, mode, keys_db
    );
endinterface

// File: rtl/stopwatch_key_ctrl_debounce.sv
// Two-flop synchroniser plus consecutive-sample debouncer for one
// active-low key; press is high for the one cycle after db rises.
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEB_SAMPLES = DEB_SAMPLES_DEF
) (
    input  logic clk10h,
    input  logic rst,
    input  logic key_n,
    output logic db,
    output logic press
);
    localparam int DW = cnt_width(DEB_SAMPLES - 1);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d, db_prev_q;
    logic [DW-1:0] cnt_q, cnt_d;

    // Debounce counter and level update from the synchronised sample
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync2_q != db_q) begin
            if (cnt_q == DW'(DEB_SAMPLES - 1)) begin
                db_d  = sync2_q;
                cnt_d = {DW{1'b0}};
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end else begin
            cnt_d = {DW{1'b0}};
        end
    end

    // Synchroniser, debounce state and previous level for edge detection
    always_ff @(posedge clk10h or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= {DW{1'b0}};
        end else begin
            sync1_q   <= ~key_n;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    assign db    = db_q;
    assign press = db_q & ~db_prev_q;
endmodule

// File: rtl/stopwatch_key_ctrl.sv
// Stopwatch key control: debounces start/stop/add, runs the IDLE/RUN/PAUSE
// mode machine and produces run level, increment (with auto-repeat) and
// clear pulses for the counter stage.
module stopwatch_key_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEB_SAMPLES  = DEB_SAMPLES_DEF,
    parameter int HOLD_TICKS   = HOLD_TICKS_DEF,
    parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
    input  logic                  clk10h,
    input  logic                  rst,
    stopwatch_key_ctrl_if.slave   bus
);
    localparam int HW = cnt_width(HOLD_TICKS + REPEAT_TICKS);

    logic [2:0]    key_n_s, db_s, press_s;
    logic          start_ev_s, stop_ev_s, add_ev_s, add_db_s, rep_fire_s;
    mode_e         mode_q, mode_d;
    logic          run_q, run_d, inc_q, inc_d, clr_q, clr_d;
    logic          armed_q, armed_d;
    logic [HW-1:0] hold_q, hold_d;

    assign key_n_s = {bus.add_n, bus.stop_n, bus.start_n};

    for (genvar i = 0; i < 3; i++) begin : g_key
        key_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
            .clk10h (clk10h),
            .rst    (rst),
            .key_n  (key_n_s[i]),
            .db     (db_s[i]),
            .press  (press_s[i])
        );
    end

    assign start_ev_s = press_s[KEY_START];
    assign stop_ev_s  = press_s[KEY_STOP];
    assign add_ev_s   = press_s[KEY_ADD];
    assign add_db_s   = db_s[KEY_ADD];

    // Hold counter: restarts on the press, counts while held, reloads to
    // HOLD_TICKS after each repeat period and clears on release
    always_comb begin
        hold_d = hold_q;
        if (add_ev_s) begin
            hold_d = {HW{1'b0}};
        end else if (add_db_s) begin
            if (hold_q == HW'(HOLD_TICKS + REPEAT_TICKS - 1)) begin
                hold_d = HW'(HOLD_TICKS);
            end else begin
                hold_d = hold_q + HW'(1);
            end
        end else begin
            hold_d = {HW{1'b0}};
        end
    end

    assign rep_fire_s = add_db_s & ~add_ev_s & (hold_d == HW'(HOLD_TICKS));

    // Mode machine and next-state of the registered pulse outputs
    always_comb begin
        mode_d = mode_q;
        inc_d  = 1'b0;
        clr_d  = 1'b0;
        case (mode_q)
            MODE_IDLE: begin
                if (stop_ev_s) begin
                    clr_d = 1'b1;
                end else if (start_ev_s) begin
                    mode_d = MODE_RUN;
                end else if (armed_q && (add_ev_s || rep_fire_s)) begin
                    inc_d = 1'b1;
                end else begin
                    inc_d = 1'b0;
                end
            end
            MODE_RUN: begin
                if (stop_ev_s) begin
                    mode_d = MODE_PAUSE;
                end else begin
                    mode_d = MODE_RUN;
                end
            end
            MODE_PAUSE: begin
                if (stop_ev_s) begin
                    mode_d = MODE_IDLE;
                    clr_d  = 1'b1;
                end else if (start_ev_s) begin
                    mode_d = MODE_RUN;
                end else if (armed_q && (add_ev_s || rep_fire_s)) begin
                    inc_d = 1'b1;
                end else begin
                    inc_d = 1'b0;
                end
            end
            default: begin
                mode_d = MODE_IDLE;
            end
        endcase
        run_d = (mode_d == MODE_RUN);
    end

    // Arming: held low for all of RUN so an add still held on leaving RUN
    // stays silent until it is released outside RUN
    always_comb begin
        if (mode_d == MODE_RUN) begin
            armed_d = 1'b0;
        end else if (!add_db_s) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk10h or negedge rst) begin
        if (!rst) begin
            mode_q  <= MODE_IDLE;
            run_q   <= 1'b0;
            inc_q   <= 1'b0;
            clr_q   <= 1'b0;
            armed_q <= 1'b1;
            hold_q  <= {HW{1'b0}};
        end else begin
            mode_q  <= mode_d;
            run_q   <= run_d;
            inc_q   <= inc_d;
            clr_q   <= clr_d;
            armed_q <= armed_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.mode      = mode_q;
    assign bus.run       = run_q;
    assign bus.inc_pulse = inc_q;
    assign bus.clr_pulse = clr_q;
    assign bus.keys_db   = db_s;
endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// Directed bench for stopwatch_key_ctrl with hand-computed pulse timing.
// A key driven just after edge m is first seen at edge m+1; its event
// reaches the outputs at edge m+5 (default parameters).
module tb_stopwatch_key_ctrl;
    logic clk10h = 1'b0;
    logic rst    = 1'b0;
    int   cyc    = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   overlap  = 0;
    int   mark;
    int   inc_q[$];
    int   clr_q[$];

    stopwatch_key_ctrl_if bus ();

    stopwatch_key_ctrl dut (
        .clk10h (clk10h),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk10h = ~clk10h;

    // Edge counter
    always @(posedge clk10h) cyc <= cyc + 1;

    // Pulse logger, sampled mid-cycle
    always @(negedge clk10h) begin
        if (bus.inc_pulse) inc_q.push_back(cyc);
        if (bus.clr_pulse) clr_q.push_back(cyc);
        if (bus.inc_pulse && bus.clr_pulse) overlap++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk10h);
            #1;
        end
    endtask

    initial begin
        bus.start_n = 1'b1;
        bus.stop_n  = 1'b1;
        bus.add_n   = 1'b1;
        step(3);
        chk("rst_mode", bus.mode, 0);
        chk("rst_run", bus.run, 0);
        chk("rst_inc", bus.inc_pulse, 0);
        chk("rst_clr", bus.clr_pulse, 0);
        chk("rst_keys", bus.keys_db, 0);

        // Start held from release of reset
        rst = 1'b1;
        bus.start_n = 1'b0;
        step(4);
        chk("start_keys_db", bus.keys_db, 1);
        chk("start_run_early", bus.run, 0);
        step(1);
        chk("start_run", bus.run, 1);
        chk("start_mode", bus.mode, 1);
        bus.start_n = 1'b1;
        step(6);
        chk("start_no_inc", inc_q.size(), 0);
        chk("start_no_clr", clr_q.size(), 0);

        // One-cycle stop glitch in RUN
        bus.stop_n = 1'b0;
        step(1);
        bus.stop_n = 1'b1;
        step(8);
        chk("glitch_mode", bus.mode, 1);
        chk("glitch_keys", bus.keys_db, 0);

        // Stop held 3 cycles -> PAUSE
        bus.stop_n = 1'b0;
        step(3);
        bus.stop_n = 1'b1;
        step(1);
        chk("stop_mode_early", bus.mode, 1);
        step(1);
        chk("stop_mode", bus.mode, 2);
        chk("stop_run", bus.run, 0);
        step(6);

        // Short add press in PAUSE -> one pulse
        inc_q.delete();
        mark = cyc;
        bus.add_n = 1'b0;
        step(5);
        bus.add_n = 1'b1;
        step(10);
        chk("add_cnt", inc_q.size(), 1);
        chk("add_at", inc_q[0], mark + 5);

        // Add held 20 cycles -> P, P+10, P+13, P+16, P+19
        inc_q.delete();
        mark = cyc;
        bus.add_n = 1'b0;
        step(20);
        bus.add_n = 1'b1;
        step(8);
        chk("hold_cnt", inc_q.size(), 5);
        chk("hold_p0", inc_q[0], mark + 5);
        chk("hold_p1", inc_q[1], mark + 15);
        chk("hold_p2", inc_q[2], mark + 18);
        chk("hold_p3", inc_q[3], mark + 21);
        chk("hold_p4", inc_q[4], mark + 24);
        chk("hold_mode", bus.mode, 2);

        // Stop in PAUSE -> clear, IDLE
        clr_q.delete();
        mark = cyc;
        bus.stop_n = 1'b0;
        step(3);
        bus.stop_n = 1'b1;
        step(6);
        chk("pstop_clr_cnt", clr_q.size(), 1);
        chk("pstop_clr_at", clr_q[0], mark + 5);
        chk("pstop_mode", bus.mode, 0);

        // Start and stop together in IDLE -> stop wins
        clr_q.delete();
        bus.start_n = 1'b0;
        bus.stop_n  = 1'b0;
        step(3);
        bus.start_n = 1'b1;
        bus.stop_n  = 1'b1;
        step(2);
        chk("both_clr", bus.clr_pulse, 1);
        chk("both_mode", bus.mode, 0);
        chk("both_run", bus.run, 0);
        step(1);
        chk("both_clr_one", bus.clr_pulse, 0);
        step(5);
        chk("both_clr_cnt", clr_q.size(), 1);

        // Enter RUN, hold add, then stop -> PAUSE with add still held
        bus.start_n = 1'b0;
        step(3);
        bus.start_n = 1'b1;
        step(2);
        chk("run2_mode", bus.mode, 1);
        step(4);
        inc_q.delete();
        bus.add_n = 1'b0;
        step(15);
        chk("run_add_ignored", inc_q.size(), 0);
        bus.stop_n = 1'b0;
        step(3);
        bus.stop_n = 1'b1;
        step(2);
        chk("held_pause_mode", bus.mode, 2);
        step(20);
        chk("held_no_inc", inc_q.size(), 0);
        bus.add_n = 1'b1;
        step(6);
        chk("released_no_inc", inc_q.size(), 0);
        mark = cyc;
        bus.add_n = 1'b0;
        step(7);
        chk("rearm_cnt", inc_q.size(), 1);
        chk("rearm_at", inc_q[0], mark + 5);
        step(3);
        chk("midhold_keys", bus.keys_db, 4);

        // Asynchronous reset mid-hold
        rst = 1'b0;
        #1;
        chk("arst_mode", bus.mode, 0);
        chk("arst_run", bus.run, 0);
        chk("arst_inc", bus.inc_pulse, 0);
        chk("arst_clr", bus.clr_pulse, 0);
        chk("arst_keys", bus.keys_db, 0);
        chk("no_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/stopwatch_key_ctrl.md
Name: stopwatch_key_ctrl

Overview:
Upstream control stage for the 0.0–9.9 s stopwatch counter. It synchronises and debounces the three raw active-low keys (start, stop, add) on the 10 Hz tick clock, and runs the IDLE/RUN/PAUSE mode machine. It emits a run level, single-cycle increment pulses (with long-press auto-repeat) and a clear pulse. The counter stage consumes these instead of raw key levels.

Parameters:
DEB_SAMPLES, 2, consecutive cycles a synchronised key must differ from its debounced level before the level changes (min 1)
HOLD_TICKS, 10, cycles from the add press event to the first auto-repeat pulse (1.0 s)
REPEAT_TICKS, 3, cycles between subsequent auto-repeat pulses (0.3 s)

Ports:
clk10h  input  1  10 Hz tick clock
rst  input  1  reset, asynchronous, active-low
start_n  input  1  raw start key, 0 = pressed, asynchronous
stop_n  input  1  raw stop key, 0 = pressed, asynchronous
add_n  input  1  raw add key, 0 = pressed, asynchronous
run  output  1  1 while in RUN; counter advances every cycle when high
inc_pulse  output  1  one-cycle request to add 0.1 to the count
clr_pulse  output  1  one-cycle request to zero the count
mode  output  2  current state: 0 IDLE, 1 RUN, 2 PAUSE (3 unused)
keys_db  output  3  debounced pressed levels {add, stop, start}, 1 = pressed

Behaviour:
- Reset (rst=0, async): mode=IDLE, run=0, inc_pulse=0, clr_pulse=0, keys_db=0, synchronisers=0 (released), debounce counters=0, hold counter=0, add_armed=1.
- Per key: invert, then pass through a 2-flop synchroniser. The debounce counter increments each cycle that the sync output differs from db. It clears when they are equal. When the counter reaches DEB_SAMPLES-1 and the inputs still differ, db takes the sync value and the counter clears.
- Press event = db rises (registered db_d=0, db=1). Release event is not used except for add re-arming.
- Latency: key pressed before edge k -> db changes at edge k+1+DEB_SAMPLES -> mode/run/pulses update at edge k+2+DEB_SAMPLES. With defaults this is edge k+4.
- Glitch shorter than DEB_SAMPLES cycles at the sync output -> no db change, no event.
- State machine, evaluated on press events in the same cycle:
  - IDLE: start -> RUN. Stop -> stay IDLE, clr_pulse. Add -> inc_pulse.
  - RUN: stop -> PAUSE. Start ignored. Add ignored.
  - PAUSE: start -> RUN. Stop -> IDLE, clr_pulse. Add -> inc_pulse.
- Simultaneous press events: stop beats start. Start or stop beats add, so no inc_pulse when either fires in the same cycle.
- run = (mode==RUN). It is registered and changes on the same edge as mode.
- Auto-repeat, only in IDLE/PAUSE and only while add_armed:
  - The hold counter clears on the add press event.
  - It increments while add db=1.
  - inc_pulse fires when the counter reaches HOLD_TICKS, then every REPEAT_TICKS after that.
  - The counter saturates/reloads so it never overflows. Width is $clog2(HOLD_TICKS+REPEAT_TICKS+1).
- Entering RUN clears add_armed. add_armed sets again only when add db=0. Result: an add held across RUN->PAUSE produces no pulses until it is released and pressed again.
- add db falling -> hold counter cleared, no pulse.
- Every pulse lasts exactly one cycle. inc_pulse and clr_pulse are never high together.
- Key held through reset release: db starts released, so a normal press event follows after the standard latency.
- mode encoding 3 is unreachable. If reached, it recovers to IDLE on the next edge.

Decomposition:
- Shared package stopwatch_pkg (or include header):
  - Mode encodings MODE_IDLE/RUN/PAUSE.
  - Key index constants KEY_START=0, KEY_STOP=1, KEY_ADD=2.
  - Default tick constants, shared with the counter stage.
- One sub-module, key_debounce: synchroniser plus debounce counter, parameter DEB_SAMPLES. Ports clk10h, rst, key_n, db, press. It is instantiated three times.
- The FSM and auto-repeat logic stay in stopwatch_key_ctrl.

Test Plan:
- Reset, then start_n=0 held from cycle 0 -> run=1, mode=1 at edge 4. inc_pulse and clr_pulse stay 0.
- From RUN, stop_n=0 one-cycle glitch -> no change. stop_n=0 held 3 cycles -> mode=2, run=0 at edge 4 after assertion.
- In PAUSE, add_n pressed then released after 5 cycles -> exactly one inc_pulse, at edge 4.
- In PAUSE, add_n held 20 cycles -> inc_pulse at press edge P, P+10, P+13, P+16, P+19. Total 5 pulses.
- In PAUSE, press stop -> clr_pulse for 1 cycle, mode=0. Press start and stop together from IDLE -> clr_pulse, mode stays 0.
- Add held while in RUN, then stop pressed -> mode=2, no inc_pulse until add released ≥DEB_SAMPLES cycles and pressed again. Assert rst=0 mid-hold -> all outputs 0 immediately.
